rr_pipe_sched: RTL
==================

Name: rr_pipe_sched

Overview:
- Round-robin scheduler that shares one fixed-latency, non-stallable datapath pipeline of depth PIPE_DEPTH among NUM_REQ requesters.
- Arbitrates one issue per cycle and drives the pipeline input.
- Tracks the owner of every in-flight slot with an internal valid/ID chain.
- Steers each result back to the requester that issued it, PIPE_DEPTH cycles after issue.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 32, width of request and result data.
- PIPE_DEPTH, 2, latency in cycles of the shared pipeline (>=1).
- ID_W, $clog2(NUM_REQ), requester index width (derived, not overridable).
- CNT_W, $clog2(PIPE_DEPTH+1), in-flight counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable_i  in  1  when low, no new grants; in-flight slots drain normally.
- flush_i  in  1  kill all in-flight slots; blocks issue this cycle.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_data_i  in  NUM_REQ x DATA_W  per-requester request data.
- req_ready_o  out  NUM_REQ  one-hot grant; transfer when valid & ready.
- pipe_valid_o  out  1  issue strobe to the shared pipeline.
- pipe_data_o  out  DATA_W  data of the granted requester.
- pipe_id_o  out  ID_W  index of the granted requester.
- pipe_result_i  in  DATA_W  pipeline output, aligned PIPE_DEPTH cycles after issue.
- rsp_valid_o  out  NUM_REQ  one-hot result strobe, no backpressure.
- rsp_data_o  out  DATA_W  result data (equals pipe_result_i).
- inflight_o  out  CNT_W  number of valid in-flight slots.
- idle_o  out  1  high when inflight_o==0.

Behaviour:
- Reset: rr pointer <= NUM_REQ-1, so requester 0 has priority first. All tracking valids <= 0 and inflight_o <= 0. Every output then evaluates to 0 except idle_o=1, and rsp_data_o, which follows pipe_result_i.
- Arbitration is combinational within the cycle:
  - Search req_valid_i starting at pointer+1 mod NUM_REQ; the first set bit wins.
  - Grant is suppressed when enable_i=0, flush_i=1, or rst=1.
  - req_ready_o = one-hot grant. pipe_valid_o = |grant. pipe_data_o = req_data_i[winner]. pipe_id_o = winner.
  - With no grant, pipe_data_o and pipe_id_o are 0.
- Pointer updates to the winner on the clock edge after a grant; otherwise it holds. Disabled, flushed and empty cycles do not move the pointer.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 grants.
- Tracking chain has PIPE_DEPTH stages of {valid, id}:
  - Stage 0 captures {pipe_valid_o, pipe_id_o}; stage k captures stage k-1 every cycle. There is no stall.
  - Tail is stage PIPE_DEPTH-1. An issue in cycle T reaches the tail in cycle T+PIPE_DEPTH.
- Response: rsp_valid_o[i] = tail.valid & (tail.id==i) & ~flush_i. rsp_data_o = pipe_result_i, combinational pass-through.
- Flush:
  - In the flush cycle: no grant, and rsp_valid_o is forced to 0, including a result sitting at the tail.
  - Next cycle: every chain stage is invalid and inflight_o=0.
  - Multi-cycle flush holds this state.
- inflight_o is a counter: +1 on issue, -1 when the tail is valid. Issue and retire in the same cycle leave it unchanged. Flush loads 0. It must always equal the popcount of chain valids; the bench checks this as an assertion. It never exceeds PIPE_DEPTH.
- enable_i low: grants stop immediately, and the pipeline drains in PIPE_DEPTH cycles.
- rst mid-operation: all in-flight slots are discarded, same as a flush. No rsp_valid_o is asserted in the reset cycle.
- A requester may drop req_valid_i without a grant; the request is then simply not granted.

Test Plan:
- Back-to-back grants: NUM_REQ=4, PIPE_DEPTH=2, all valid for 8 cycles, req_data_i[i]=0x10+i, pipe_result_i = pipe_data delayed 2 cycles. Required: grants 0,1,2,3,0,1,2,3; rsp_valid_o is one-hot matching the grant 2 cycles earlier, with rsp_data_o=0x10+id; inflight_o settles at 2.
- Sparse requests: only req 2 valid at cycle 0, then only req 0 at cycle 1. Required: grant 2 then grant 0; rsp_valid_o=4'b0100 at cycle 2 and 4'b0001 at cycle 3; idle_o=1 at cycle 4.
- Flush mid-flight: issue at cycles 0 and 1, flush_i=1 at cycle 2. Required: no rsp_valid_o at cycle 2 or 3; inflight_o=0 at cycle 3; no grant at cycle 2 even with req 3 valid; req 3 granted at cycle 3.
- Enable gating: enable_i=0 while reqs 0 and 1 are valid. Required: req_ready_o=0; the pointer is unchanged; after enable_i=1, req 0 is granted first when the pointer is 3.
- Reset mid-operation: rst at cycle 1 after an issue at cycle 0. Required: inflight_o=0 and idle_o=1 at cycle 2; no rsp_valid_o at cycle 2; the next grant goes to req 0.
- Randomized regression with PIPE_DEPTH=1 and PIPE_DEPTH=5, using a scoreboard on id/data. Required: every issue is responded to exactly once unless flushed, and the inflight_o == popcount(chain valids) assertion holds throughout.

Source files
------------

// File: rtl/rr_pipe_sched.sv
// Round-robin issue scheduler for a shared fixed-latency pipeline.
// Tracks the owner of each in-flight slot and steers results back to it.
module rr_pipe_sched #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_W     = 32,
   parameter  int PIPE_DEPTH = 2,
   localparam int ID_W       = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable_i,
   input  logic                            flush_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   output logic                            pipe_valid_o,
   output logic [DATA_W-1:0]               pipe_data_o,
   output logic [ID_W-1:0]                 pipe_id_o,
   input  logic [DATA_W-1:0]               pipe_result_i,
   output logic [NUM_REQ-1:0]              rsp_valid_o,
   output logic [DATA_W-1:0]               rsp_data_o,
   output logic [CNT_W-1:0]                inflight_o,
   output logic                            idle_o
);

   logic [ID_W-1:0]                  ptr, win_id, cand;
   logic                             found, issue;
   logic [NUM_REQ-1:0]               grant;
   logic [PIPE_DEPTH-1:0]            vld_pipe;
   logic [PIPE_DEPTH-1:0][ID_W-1:0]  id_pipe;
   logic                             tail_vld;
   logic [ID_W-1:0]                  tail_id;
   logic [CNT_W-1:0]                 cnt;

   // Search starts one past the last winner so the last winner has lowest priority.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      cand   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req_valid_i[cand]) begin
            found  = 1'b1;
            win_id = cand;
         end
      end
   end

   assign issue = found & enable_i & ~flush_i & ~rst;

   always_comb begin
      grant = '0;
      if (issue) grant[win_id] = 1'b1;
   end

   assign req_ready_o  = grant;
   assign pipe_valid_o = issue;
   assign pipe_data_o  = issue ? req_data_i[win_id] : '0;
   assign pipe_id_o    = issue ? win_id : '0;

   always_ff @(posedge clk) begin
      if (rst)        ptr <= ID_W'(NUM_REQ - 1);
      else if (issue) ptr <= win_id;
   end

   // Owner chain runs in lockstep with the external pipeline; never stalls.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= issue;
         for (int k = 1; k < PIPE_DEPTH; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
      id_pipe[0] <= pipe_id_o;
      for (int k = 1; k < PIPE_DEPTH; k++) id_pipe[k] <= id_pipe[k-1];
   end

   assign tail_vld = vld_pipe[PIPE_DEPTH-1];
   assign tail_id  = id_pipe[PIPE_DEPTH-1];

   always_comb begin
      rsp_valid_o = '0;
      if (tail_vld && !flush_i && !rst) rsp_valid_o[tail_id] = 1'b1;
   end

   assign rsp_data_o = pipe_result_i;

   // Mirrors popcount(vld_pipe); issue and retire in one cycle cancel.
   always_ff @(posedge clk) begin
      if (rst || flush_i)          cnt <= '0;
      else if (issue && !tail_vld) cnt <= cnt + 1'b1;
      else if (!issue && tail_vld) cnt <= cnt - 1'b1;
   end

   assign inflight_o = cnt;
   assign idle_o     = (cnt == '0);

endmodule
